if_id_stage: RTL

Instruction-fetch to decode pipeline register, driven by the pipeline controller's stall and flush vectors. Captures fetched instructions and presents them to decode, one cycle later. Holds its contents during an IF/ID stall and turns into a NOP bubble on flush. A one-entry skid buffer keeps any fetch response that lands during a stall, so instruction-cache returns are never lost.

---
 rtl/if_id_stage.sv | 79 +++++++
 1 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with a one-entry skid buffer.
// The skid buffer keeps fetch responses that arrive during a stall.
module if_id_stage #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Fetch_Valid,
    input  logic [XLEN-1:0] Fetch_Pc,
    input  logic [XLEN-1:0] Fetch_Instr,
    input  logic            Fetch_Excp,
    output logic            Fetch_Ready,
    input  logic [4:0]      Ctrl_Stall,
    input  logic [3:0]      Flush,
    output logic            Id_Valid,
    output logic [XLEN-1:0] Id_Pc,
    output logic [XLEN-1:0] Id_Instr,
    output logic            Id_Excp,
    output logic [15:0]     Id_HoldCnt
);
    logic            skidValid;
    logic [XLEN-1:0] skidPc;
    logic [XLEN-1:0] skidInstr;
    logic            skidExcp;
    logic            accept;
    logic            unusedBits;

    assign unusedBits  = ^{Ctrl_Stall[4:2], Ctrl_Stall[0], Flush[3:1]};
    assign Fetch_Ready = !skidValid;
    assign accept      = Fetch_Valid && !skidValid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Id_Valid   <= 1'b0;
            Id_Pc      <= '0;
            Id_Instr   <= NOP_INSTR;
            Id_Excp    <= 1'b0;
            Id_HoldCnt <= '0;
            skidValid  <= 1'b0;
            skidPc     <= '0;
            skidInstr  <= NOP_INSTR;
            skidExcp   <= 1'b0;
        end else if (Flush[0]) begin
            Id_Valid   <= 1'b0;
            Id_Instr   <= NOP_INSTR;
            Id_Excp    <= 1'b0;
            Id_HoldCnt <= '0;
            skidValid  <= 1'b0;
        end else if (Ctrl_Stall[1]) begin
            if (accept) begin
                skidValid <= 1'b1;
                skidPc    <= Fetch_Pc;
                skidInstr <= Fetch_Instr;
                skidExcp  <= Fetch_Excp;
            end
            Id_HoldCnt <= !Id_Valid ? 16'h0 : (&Id_HoldCnt) ? Id_HoldCnt : Id_HoldCnt + 16'h1;
        end else begin
            // A full skid blocks accept, so the skid entry always drains before newer fetches
            if (skidValid) begin
                Id_Valid <= 1'b1;
                Id_Pc    <= skidPc;
                Id_Instr <= skidInstr;
                Id_Excp  <= skidExcp;
            end else if (accept) begin
                Id_Valid <= 1'b1;
                Id_Pc    <= Fetch_Pc;
                Id_Instr <= Fetch_Instr;
                Id_Excp  <= Fetch_Excp;
            end else begin
                Id_Valid <= 1'b0;
                Id_Instr <= NOP_INSTR;
                Id_Excp  <= 1'b0;
            end
            skidValid  <= 1'b0;
            Id_HoldCnt <= '0;
        end
    end
endmodule
